// File: rtl/video_pkg.sv
// Shared types, colour constants and raster-geometry helpers for the video source.
package video_pkg;

   localparam int CNT_W = 12;
   localparam int PIX_W = 11;

   typedef logic [15:0] rgb565_t;

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_GRID  = 2'd1,
      PAT_RAMP  = 2'd2,
      PAT_SOLID = 2'd3
   } pat_mode_e;

   localparam rgb565_t RGB_WHITE   = 16'hFFFF;
   localparam rgb565_t RGB_YELLOW  = 16'hFFE0;
   localparam rgb565_t RGB_CYAN    = 16'h07FF;
   localparam rgb565_t RGB_GREEN   = 16'h07E0;
   localparam rgb565_t RGB_MAGENTA = 16'hF81F;
   localparam rgb565_t RGB_RED     = 16'hF800;
   localparam rgb565_t RGB_BLUE    = 16'h001F;
   localparam rgb565_t RGB_BLACK   = 16'h0000;

   function automatic int line_total(int sync, int bp, int act, int fp);
      return sync + bp + act + fp;
   endfunction

   function automatic int active_start(int sync, int bp);
      return sync + bp;
   endfunction

   function automatic rgb565_t bar_colour(logic [2:0] idx);
      case (idx)
         3'd0: return RGB_WHITE;
         3'd1: return RGB_YELLOW;
         3'd2: return RGB_CYAN;
         3'd3: return RGB_GREEN;
         3'd4: return RGB_MAGENTA;
         3'd5: return RGB_RED;
         3'd6: return RGB_BLUE;
         default: return RGB_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/video_timing.sv
// Raster counters plus registered sync/de/position decode; also exposes the
// unregistered position of the current count so the pattern path stays aligned.
module video_timing
   import video_pkg::*;
#(
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic             vga_clk,
   input  logic             sys_rst_n,
   output logic             act_c,
   output logic             origin_c,
   output logic [PIX_W-1:0] x_c,
   output logic [PIX_W-1:0] y_c,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [PIX_W-1:0] pix_x,
   output logic [PIX_W-1:0] pix_y,
   output logic             frame_start
);

   localparam int H_TOTAL = line_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
   localparam int V_TOTAL = line_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
   localparam int H_ST    = active_start(H_SYNC, H_BP);
   localparam int V_ST    = active_start(V_SYNC, V_BP);

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_START = CNT_W'(H_ST);
   localparam logic [CNT_W-1:0] V_START = CNT_W'(V_ST);
   localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_ST + H_ACTIVE);
   localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_ST + V_ACTIVE);
   localparam logic [CNT_W-1:0] H_SEND  = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SEND  = CNT_W'(V_SYNC);

   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic             h_act, v_act;

   always_comb begin
      h_act    = (h_cnt >= H_START) && (h_cnt < H_END);
      v_act    = (v_cnt >= V_START) && (v_cnt < V_END);
      act_c    = h_act && v_act;
      origin_c = (h_cnt == '0) && (v_cnt == '0);
      x_c      = act_c ? PIX_W'(h_cnt - H_START) : '0;
      y_c      = act_c ? PIX_W'(v_cnt - V_START) : '0;
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
         h_cnt <= h_cnt + CNT_W'(1);
      end
   end

   // Outputs describe the count held during this cycle, one clock late.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= (h_cnt < H_SEND) ? HS_POL : ~HS_POL;
         vsync       <= (v_cnt < V_SEND) ? VS_POL : ~VS_POL;
         de          <= act_c;
         pix_x       <= x_c;
         pix_y       <= y_c;
         frame_start <= origin_c;
      end
   end

endmodule

// File: rtl/video_pattern_gen.sv
// Video source top: raster timing plus frame-latched test-pattern selection,
// emitting aligned hsync/vsync/de/position/RGB565.
module video_pattern_gen
   import video_pkg::*;
#(
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic             vga_clk,
   input  logic             sys_rst_n,
   input  logic [1:0]       pat_mode,
   input  logic [15:0]      solid_rgb,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [PIX_W-1:0] pix_x,
   output logic [PIX_W-1:0] pix_y,
   output logic             frame_start,
   output logic [15:0]      rgb
);

   localparam int               BAR_W    = H_ACTIVE / 8;
   localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
   localparam logic [PIX_W-1:0] X_LAST   = PIX_W'(H_ACTIVE - 1);
   localparam logic [PIX_W-1:0] Y_LAST   = PIX_W'(V_ACTIVE - 1);

   logic             act_c, origin_c;
   logic [PIX_W-1:0] x_c, y_c;
   pat_mode_e        mode_q;
   rgb565_t          solid_q, pat;
   logic [2:0]       bar_idx;
   logic [CNT_W-1:0] bar_cnt;
   logic [4:0]       grey;

   video_timing #(
      .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
      .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
      .HS_POL(HS_POL), .VS_POL(VS_POL)
   ) u_timing (
      .vga_clk(vga_clk), .sys_rst_n(sys_rst_n),
      .act_c(act_c), .origin_c(origin_c), .x_c(x_c), .y_c(y_c),
      .hsync(hsync), .vsync(vsync), .de(de),
      .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
   );

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mode_q  <= PAT_BARS;
         solid_q <= RGB_BLACK;
      end else if (origin_c) begin
         mode_q  <= pat_mode_e'(pat_mode);
         solid_q <= solid_rgb;
      end
   end

   // Bar position tracks x_c; the last bar keeps counting to absorb the remainder.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bar_idx <= '0;
         bar_cnt <= '0;
      end else if (!act_c) begin
         bar_idx <= '0;
         bar_cnt <= '0;
      end else if ((bar_cnt == BAR_LAST) && (bar_idx != 3'd7)) begin
         bar_idx <= bar_idx + 3'd1;
         bar_cnt <= '0;
      end else begin
         bar_cnt <= bar_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      grey = x_c[10] ? 5'd31 : x_c[9:5];
      pat  = RGB_BLACK;
      case (mode_q)
         PAT_BARS:  pat = bar_colour(bar_idx);
         PAT_GRID:  pat = ((x_c[4:0] == 5'd0) || (y_c[4:0] == 5'd0) ||
                           (x_c == X_LAST) || (y_c == Y_LAST)) ? RGB_WHITE : RGB_BLACK;
         PAT_RAMP:  pat = {grey, grey, 1'b0, grey};
         PAT_SOLID: pat = solid_q;
         default:   pat = RGB_BLACK;
      endcase
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) rgb <= '0;
      else            rgb <= act_c ? pat : '0;
   end

endmodule
